// File: rtl/vga_frame_source.sv
// -----------------------------------------------------------------------------
// vga_frame_source
//
// VGA transmitter. A pair of 13-bit raster counters (H_Cont / V_Cont) drives a
// stage-0 decode of HS, VS and BLANK_N. Active positions issue a registered
// read request (pix_rd / pix_x / pix_y) to a synchronous frame store with
// 1-cycle read latency. The sync/blank flags travel through three register
// stages so that a raster position decoded at cycle t is on every oVGA_*
// output at cycle t+3, aligned with the RGB sampled from the frame store.
//
// Optional feature (macro VGA_TEST_PATTERN_EN):
//   adds input pattern_sel; when high for a pixel, no read is issued and the
//   pixel colour is {x[7:0], y[7:0], (x+y)[7:0]} instead of pix_data.
//
// Ports:
//   VGA_CLK       in   pixel clock (only clock)
//   reset         in   synchronous, active-high reset
//   enable        in   run; low forces counters to 0 and idles stage 0
//   pattern_sel   in   (VGA_TEST_PATTERN_EN only) select internal pattern
//   pix_rd        out  frame-store read strobe
//   pix_x, pix_y  out  read column / row (0 when pix_rd=0)
//   pix_data      in   {R,G,B}, valid the cycle after pix_rd
//   oVGA_R/G/B    out  colour, forced 0 while oVGA_BLANK_N=0
//   oVGA_HS/VS    out  active-low syncs
//   oVGA_SYNC_N   out  constant 0
//   oVGA_BLANK_N  out  high during active pixels
//   frame_start   out  1-cycle pulse with pixel (0,0) on the outputs
//   frame_count   out  frames emitted, wraps 255 -> 0
// -----------------------------------------------------------------------------
module vga_frame_source #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int H_SYNC_CYC   = 96,
  parameter int H_SYNC_BACK  = 48,
  parameter int H_SYNC_FRONT = 16,
  parameter int V_SYNC_CYC   = 2,
  parameter int V_SYNC_BACK  = 33,
  parameter int V_SYNC_FRONT = 10
) (
  input  logic        VGA_CLK,
  input  logic        reset,
  input  logic        enable,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        pattern_sel,
`endif
  output logic        pix_rd,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  input  logic [23:0] pix_data,
  output logic [7:0]  oVGA_R,
  output logic [7:0]  oVGA_G,
  output logic [7:0]  oVGA_B,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_SYNC_N,
  output logic        oVGA_BLANK_N,
  output logic        frame_start,
  output logic [7:0]  frame_count
);

  // Raster geometry: the blanking interval comes first in each line / frame,
  // active video occupies the tail.
  localparam int H_BLANK_I = H_SYNC_FRONT + H_SYNC_CYC + H_SYNC_BACK;
  localparam int H_TOTAL_I = H_BLANK_I + WIDTH;
  localparam int V_BLANK_I = V_SYNC_FRONT + V_SYNC_CYC + V_SYNC_BACK;
  localparam int V_TOTAL_I = V_BLANK_I + HEIGHT;

  localparam logic [12:0] H_BLANK_C = 13'(H_BLANK_I);
  localparam logic [12:0] H_LAST_C  = 13'(H_TOTAL_I - 1);
  localparam logic [12:0] HS_LO_C   = 13'(H_SYNC_FRONT);
  localparam logic [12:0] HS_HI_C   = 13'(H_SYNC_FRONT + H_SYNC_CYC);
  localparam logic [12:0] V_BLANK_C = 13'(V_BLANK_I);
  localparam logic [12:0] V_LAST_C  = 13'(V_TOTAL_I - 1);
  localparam logic [12:0] VS_LO_C   = 13'(V_SYNC_FRONT);
  localparam logic [12:0] VS_HI_C   = 13'(V_SYNC_FRONT + V_SYNC_CYC);

  // Raster counters
  logic [12:0] h_cont_q, h_cont_d;
  logic [12:0] v_cont_q, v_cont_d;

  // Stage-0 decode (combinational from the counters)
  logic        hs_s, vs_s, blank_n_s, sof_s, rd_s;
  logic [9:0]  x_s, y_s;

  // Stage 1
  logic        hs1_q, vs1_q, blank1_q, sof1_q;
  logic        pix_rd_q;
  logic [9:0]  pix_x_q, pix_y_q;

  // Stage 2
  logic        hs2_q, vs2_q, blank2_q, sof2_q;

  // Stage 3 (outputs)
  logic        hs3_q, vs3_q, blank3_q, sof3_q;
  logic [23:0] rgb_q, rgb_d;
  logic [7:0]  frame_count_q, frame_count_d;

`ifdef VGA_TEST_PATTERN_EN
  logic        pat1_q, pat2_q;
  logic [23:0] pat_rgb1_q, pat_rgb2_q;
`endif

  // Next raster position; a disabled generator parks at (0,0) so that it
  // restarts cleanly from the top-left corner.
  always_comb begin
    h_cont_d = 13'd0;
    v_cont_d = 13'd0;
    if (!enable) begin
      h_cont_d = 13'd0;
      v_cont_d = 13'd0;
    end else if (h_cont_q == H_LAST_C) begin
      h_cont_d = 13'd0;
      if (v_cont_q == V_LAST_C) begin
        v_cont_d = 13'd0;
      end else begin
        v_cont_d = v_cont_q + 13'd1;
      end
    end else begin
      h_cont_d = h_cont_q + 13'd1;
      v_cont_d = v_cont_q;
    end
  end

  // Raster counter registers
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      h_cont_q <= 13'd0;
      v_cont_q <= 13'd0;
    end else begin
      h_cont_q <= h_cont_d;
      v_cont_q <= v_cont_d;
    end
  end

  // Stage-0 decode; idle values are injected while disabled.
  always_comb begin
    hs_s      = 1'b1;
    vs_s      = 1'b1;
    blank_n_s = 1'b0;
    sof_s     = 1'b0;
    x_s       = 10'd0;
    y_s       = 10'd0;
    if (enable) begin
      hs_s      = ~((h_cont_q > HS_LO_C) && (h_cont_q <= HS_HI_C));
      vs_s      = ~((v_cont_q > VS_LO_C) && (v_cont_q <= VS_HI_C));
      blank_n_s = (h_cont_q >= H_BLANK_C) && (v_cont_q >= V_BLANK_C);
      // First active position of the frame is pixel (0,0).
      sof_s     = (h_cont_q == H_BLANK_C) && (v_cont_q == V_BLANK_C);
      x_s       = 10'(h_cont_q - H_BLANK_C);
      y_s       = 10'(v_cont_q - V_BLANK_C);
    end else begin
      hs_s      = 1'b1;
      vs_s      = 1'b1;
      blank_n_s = 1'b0;
      sof_s     = 1'b0;
      x_s       = 10'd0;
      y_s       = 10'd0;
    end
  end

  // Read request is suppressed for pixels taken from the internal pattern.
`ifdef VGA_TEST_PATTERN_EN
  assign rd_s = blank_n_s & ~pattern_sel;
`else
  assign rd_s = blank_n_s;
`endif

  // Stage 1: sync/blank delay plus the registered frame-store request.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      blank1_q <= 1'b0;
      sof1_q   <= 1'b0;
      pix_rd_q <= 1'b0;
      pix_x_q  <= 10'd0;
      pix_y_q  <= 10'd0;
    end else begin
      hs1_q    <= hs_s;
      vs1_q    <= vs_s;
      blank1_q <= blank_n_s;
      sof1_q   <= sof_s;
      pix_rd_q <= rd_s;
      pix_x_q  <= rd_s ? x_s : 10'd0;
      pix_y_q  <= rd_s ? y_s : 10'd0;
    end
  end

  // Stage 2: pix_data for the stage-2 position is on the bus this cycle.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
      blank2_q <= 1'b0;
      sof2_q   <= 1'b0;
    end else begin
      hs2_q    <= hs1_q;
      vs2_q    <= vs1_q;
      blank2_q <= blank1_q;
      sof2_q   <= sof1_q;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  // Pattern colour follows the same two-stage path as the read data.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      pat1_q     <= 1'b0;
      pat2_q     <= 1'b0;
      pat_rgb1_q <= 24'd0;
      pat_rgb2_q <= 24'd0;
    end else begin
      pat1_q     <= pattern_sel;
      pat2_q     <= pat1_q;
      pat_rgb1_q <= {x_s[7:0], y_s[7:0], x_s[7:0] + y_s[7:0]};
      pat_rgb2_q <= pat_rgb1_q;
    end
  end
`endif

  // Output colour source and blanking; frame counter advance.
  always_comb begin
    rgb_d         = 24'd0;
    frame_count_d = frame_count_q;
    if (blank2_q) begin
`ifdef VGA_TEST_PATTERN_EN
      if (pat2_q) begin
        rgb_d = pat_rgb2_q;
      end else begin
        rgb_d = pix_data;
      end
`else
      rgb_d = pix_data;
`endif
    end else begin
      rgb_d = 24'd0;
    end
    if (sof2_q) begin
      frame_count_d = frame_count_q + 8'd1;
    end else begin
      frame_count_d = frame_count_q;
    end
  end

  // Stage 3: output registers, all aligned to the same raster position.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      hs3_q         <= 1'b1;
      vs3_q         <= 1'b1;
      blank3_q      <= 1'b0;
      sof3_q        <= 1'b0;
      rgb_q         <= 24'd0;
      frame_count_q <= 8'd0;
    end else begin
      hs3_q         <= hs2_q;
      vs3_q         <= vs2_q;
      blank3_q      <= blank2_q;
      sof3_q        <= sof2_q;
      rgb_q         <= rgb_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign pix_rd       = pix_rd_q;
  assign pix_x        = pix_x_q;
  assign pix_y        = pix_y_q;
  assign oVGA_R       = rgb_q[23:16];
  assign oVGA_G       = rgb_q[15:8];
  assign oVGA_B       = rgb_q[7:0];
  assign oVGA_HS      = hs3_q;
  assign oVGA_VS      = vs3_q;
  assign oVGA_BLANK_N = blank3_q;
  assign oVGA_SYNC_N  = 1'b0;
  assign frame_start  = sof3_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_vga_frame_source.sv
// -----------------------------------------------------------------------------
// Directed bench for vga_frame_source. Main instance: WIDTH=HEIGHT=10 with the
// standard porches (170 clocks/line, 55 lines/frame). A second, tiny instance
// (5x5 raster, 25 clocks/frame) covers the 257-frame frame_count wrap.
// -----------------------------------------------------------------------------
module tb_vga_frame_source;

  localparam int HT    = 170;
  localparam int VT    = 55;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        en2;
  logic        force_ff = 1'b0;
  logic        pattern_sel = 1'b0;
  logic        t_pattern_sel = 1'b0;
  logic [23:0] pix_data = 24'hA5A5A5;
  logic [23:0] t_pix_data = 24'h000000;

  logic        pix_rd, oVGA_HS, oVGA_VS, oVGA_SYNC_N, oVGA_BLANK_N, frame_start;
  logic [9:0]  pix_x, pix_y;
  logic [7:0]  oVGA_R, oVGA_G, oVGA_B, frame_count;

  logic        t_pix_rd, t_hs, t_vs, t_sync_n, t_blank_n, t_frame_start;
  logic [9:0]  t_pix_x, t_pix_y;
  logic [7:0]  t_r, t_g, t_b, t_frame_count;

  int checks   = 0;
  int failures = 0;

  always #20 clk = ~clk;

  vga_frame_source #(
    .WIDTH(10), .HEIGHT(10),
    .H_SYNC_CYC(96), .H_SYNC_BACK(48), .H_SYNC_FRONT(16),
    .V_SYNC_CYC(2), .V_SYNC_BACK(33), .V_SYNC_FRONT(10)
  ) u_dut (
    .VGA_CLK(clk), .reset(reset), .enable(enable),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .pix_rd(pix_rd), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
    .oVGA_HS(oVGA_HS), .oVGA_VS(oVGA_VS), .oVGA_SYNC_N(oVGA_SYNC_N),
    .oVGA_BLANK_N(oVGA_BLANK_N), .frame_start(frame_start),
    .frame_count(frame_count)
  );

  vga_frame_source #(
    .WIDTH(2), .HEIGHT(2),
    .H_SYNC_CYC(1), .H_SYNC_BACK(1), .H_SYNC_FRONT(1),
    .V_SYNC_CYC(1), .V_SYNC_BACK(1), .V_SYNC_FRONT(1)
  ) u_tiny (
    .VGA_CLK(clk), .reset(reset), .enable(en2),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(t_pattern_sel),
`endif
    .pix_rd(t_pix_rd), .pix_x(t_pix_x), .pix_y(t_pix_y), .pix_data(t_pix_data),
    .oVGA_R(t_r), .oVGA_G(t_g), .oVGA_B(t_b),
    .oVGA_HS(t_hs), .oVGA_VS(t_vs), .oVGA_SYNC_N(t_sync_n),
    .oVGA_BLANK_N(t_blank_n), .frame_start(t_frame_start),
    .frame_count(t_frame_count)
  );

  // Frame-store model: one-cycle read latency, junk when not reading.
  always @(posedge clk) begin
    if (force_ff)
      pix_data <= 24'hFFFFFF;
    else if (pix_rd)
      pix_data <= {pix_x[7:0], pix_y[7:0], pix_x[7:0] + pix_y[7:0]};
    else
      pix_data <= 24'hA5A5A5;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample one full frame of the main instance; index i is raster position i.
  task automatic scan_frame(input logic [7:0] exp_fc, input bit tiny);
    int h, v;
    int hs_lo, vs_lo, bl, rd, model_err, img_err, rgb_err, sync_err;
    int sof_n, sof_pos, t_sof, t_pos_err;
    logic exp_hs, exp_vs, exp_bl;
    logic [7:0] fc_at_sof, t_fc_256, t_fc_257;
    logic [23:0] exp_rgb;
    hs_lo = 0; vs_lo = 0; bl = 0; rd = 0; model_err = 0; img_err = 0;
    rgb_err = 0; sync_err = 0; sof_n = 0; sof_pos = -1; t_sof = 0; t_pos_err = 0;
    fc_at_sof = 8'hEE; t_fc_256 = 8'hEE; t_fc_257 = 8'hEE;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      h = i % HT;
      v = i / HT;
      exp_hs = !(h > 16 && h <= 112);
      exp_vs = !(v > 10 && v <= 12);
      exp_bl = (h >= 160) && (v >= 45);
      if (oVGA_HS !== exp_hs || oVGA_VS !== exp_vs || oVGA_BLANK_N !== exp_bl) model_err++;
      if (oVGA_HS === 1'b0) hs_lo++;
      if (oVGA_VS === 1'b0) vs_lo++;
      if (oVGA_BLANK_N === 1'b1) bl++;
      if (pix_rd === 1'b1) rd++;
      if (oVGA_SYNC_N !== 1'b0) sync_err++;
      if (exp_bl) begin
        exp_rgb = {8'(h - 160), 8'(v - 45), 8'(h + v - 205)};
        if ({oVGA_R, oVGA_G, oVGA_B} !== exp_rgb) img_err++;
      end else if ({oVGA_R, oVGA_G, oVGA_B} !== 24'h000000) begin
        rgb_err++;
      end
      if (frame_start === 1'b1) begin
        sof_n++;
        sof_pos = i;
        fc_at_sof = frame_count;
      end
      if (tiny && i < 6425) begin
        if (t_frame_start === 1'b1) begin
          t_sof++;
          if (i % 25 != 18) t_pos_err++;
        end
        if (i == 6400) t_fc_256 = t_frame_count;
        if (i == 6424) t_fc_257 = t_frame_count;
      end
    end
    check("hs_low_clocks", hs_lo, 32'd5280);
    check("vs_low_clocks", vs_lo, 32'd340);
    check("blank_n_high_clocks", bl, 32'd100);
    check("pix_rd_per_frame", rd, 32'd100);
    check("sync_blank_position_errs", model_err, 32'd0);
    check("image_pixel_errs", img_err, 32'd0);
    check("rgb_nonzero_in_blank", rgb_err, 32'd0);
    check("sync_n_nonzero", sync_err, 32'd0);
    check("frame_start_count", sof_n, 32'd1);
    check("frame_start_position", sof_pos, 32'd7810);
    check("frame_count_at_sof", fc_at_sof, exp_fc);
    check("frame_count_end", frame_count, exp_fc);
    if (tiny) begin
      check("tiny_sof_count_257", t_sof, 32'd257);
      check("tiny_sof_position_errs", t_pos_err, 32'd0);
      check("tiny_frame_count_256", t_fc_256, 32'd0);
      check("tiny_frame_count_257", t_fc_257, 32'd1);
    end
  endtask

  logic [7:0] fc_before;

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    en2    = 1'b1;

    // Reset held 6 cycles: everything idle.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("reset_ctrl", {oVGA_HS, oVGA_VS, oVGA_BLANK_N, oVGA_SYNC_N, pix_rd, frame_start}, 32'b110000);
      check("reset_rgb", {oVGA_R, oVGA_G, oVGA_B}, 32'd0);
      check("reset_pix_xy", {pix_x, pix_y}, 32'd0);
      check("reset_frame_count", frame_count, 32'd0);
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);

    // Frame 0 from reset, plus the 257-frame wrap on the tiny instance.
    scan_frame(8'd1, 1'b1);

    // Abort at line 50 (y=5), pixel 3: stage 0 holds that position at index 18010.
    repeat (18010 - 9349) @(negedge clk);
    fc_before = frame_count;
    check("frame_count_before_abort", fc_before, 32'd2);
    enable = 1'b0;
    @(negedge clk);
    check("inflight_blank_n", oVGA_BLANK_N, 32'd1);
    check("inflight_rgb_x1_y5", {oVGA_R, oVGA_G, oVGA_B}, {8'd1, 8'd5, 8'd6});
    @(negedge clk);
    @(negedge clk);
    check("abort_idle_ctrl", {oVGA_HS, oVGA_VS, oVGA_BLANK_N, frame_start}, 32'b1100);
    check("abort_idle_rgb", {oVGA_R, oVGA_G, oVGA_B}, 32'd0);
    check("abort_pix_rd", pix_rd, 32'd0);
    repeat (10) @(negedge clk);
    check("abort_frame_count_held", frame_count, fc_before);
    check("abort_idle_hold", {oVGA_HS, oVGA_VS, oVGA_BLANK_N, pix_rd}, 32'b1100);

    // Restart: next frame begins at H=0,V=0.
    enable = 1'b1;
    repeat (3) @(posedge clk);
    scan_frame(8'd3, 1'b0);

`ifdef VGA_TEST_PATTERN_EN
    begin
      int rd;
      logic [23:0] px37, px_blank;
      rd = 0;
      px37 = 24'h0;
      px_blank = 24'h123456;
      pattern_sel = 1'b1;
      force_ff = 1'b1;
      for (int i = 0; i < FRAME; i++) begin
        @(negedge clk);
        if (pix_rd === 1'b1) rd++;
        if (i == 9003) px37 = {oVGA_R, oVGA_G, oVGA_B};
        if (i == 8999) px_blank = {oVGA_R, oVGA_G, oVGA_B};
      end
      check("pattern_pixel_3_7", px37, {8'd3, 8'd7, 8'd10});
      check("pattern_blank_rgb", px_blank, 32'd0);
      check("pattern_pix_rd_count", rd, 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
